// File: rtl/cmsdk_dbgctrl_pkg.sv
// Shared constants and state encoding for the debug tester controller.
// Holds the escape/opcode bytes, the FSM state enum and the "no command" value.
package cmsdk_dbgctrl_pkg;

    localparam logic [7:0] ESC    = 8'h1B;
    localparam logic [7:0] OP_EN  = 8'h11;
    localparam logic [7:0] OP_DIS = 8'h12;
    localparam logic [7:0] OP_RUN = 8'h13;

    localparam logic [5:0] CMD_NONE = 6'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ESC,
        ST_ARG,
        ST_ISSUE,
        ST_WAIT_START,
        ST_WAIT_END,
        ST_REPORT
    } dbg_state_e;

    // Only the byte-decoding states count as idle from the bench's point of view.
    function automatic logic isBusy(input dbg_state_e s);
        return !((s == ST_IDLE) || (s == ST_ESC));
    endfunction

endpackage

// File: rtl/cmsdk_dbgctrl_timer.sv
// Wait-state timeout counter for the debug tester controller.
// Clears on request, counts while enabled, saturates at TIMEOUT_CYC.
module cmsdk_dbgctrl_timer
    import cmsdk_dbgctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 65536,
    parameter int CNT_W       = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic inc_i,
    output logic expire_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CNT_W'(TIMEOUT_CYC))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry fires in the last allowed wait cycle so the FSM can leave on that edge.
    assign expire_o = inc_i && (count_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/cmsdk_debug_tester_ctrl.sv
// Sequences the MCU debug tester from ESC-prefixed bytes on the StdOut UART stream.
// Optional wait-state timeout is built when CMSDK_DBGCTRL_TIMEOUT_EN is defined.
module cmsdk_debug_tester_ctrl
    import cmsdk_dbgctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 65536,
    parameter int CNT_W       = 17
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VALID,
    input  logic       DEBUG_RUNNING,
    input  logic       DEBUG_ERR,
    output logic       DEBUG_TESTER_ENABLE,
    output logic [5:0] DEBUG_COMMAND,
    output logic       CMD_DONE,
    output logic       CMD_FAIL,
    output logic       CMD_TIMEOUT,
    output logic       BUSY
);

    dbg_state_e state_q, state_d;

    logic       enable_q,  enable_d;
    logic [5:0] cmd_q,     cmd_d;
    logic [5:0] arg_q,     arg_d;
    logic       failLat_q, failLat_d;
    logic       tmoLat_q,  tmoLat_d;
    logic       done_q,    done_d;
    logic       fail_q,    fail_d;
    logic       tmo_q,     tmo_d;

    logic       timerExpire;
    logic       runRejected;

`ifdef CMSDK_DBGCTRL_TIMEOUT_EN
    logic timerClear;
    logic timerInc;

    assign timerClear = (state_q == ST_ISSUE) ||
                        ((state_q == ST_WAIT_START) && DEBUG_RUNNING);
    assign timerInc   = (state_q == ST_WAIT_START) || (state_q == ST_WAIT_END);

    cmsdk_dbgctrl_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk      (CLK),
        .rst_n    (RESETn),
        .clear_i  (timerClear),
        .inc_i    (timerInc),
        .expire_o (timerExpire)
    );
`else
    assign timerExpire = 1'b0;
`endif

    // A run is refused outright when there is nothing to send or no tester attached.
    assign runRejected = (RX_DATA[5:0] == CMD_NONE) || !enable_q;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (RX_VALID && (RX_DATA == ESC)) state_d = ST_ESC;
            end
            ST_ESC: begin
                if (RX_VALID) state_d = (RX_DATA == OP_RUN) ? ST_ARG : ST_IDLE;
            end
            ST_ARG: begin
                if (RX_VALID) state_d = runRejected ? ST_REPORT : ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (DEBUG_RUNNING)    state_d = ST_WAIT_END;
                else if (timerExpire) state_d = ST_REPORT;
            end
            ST_WAIT_END: begin
                if (!DEBUG_RUNNING || timerExpire) state_d = ST_REPORT;
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        enable_d  = enable_q;
        cmd_d     = cmd_q;
        arg_d     = arg_q;
        failLat_d = failLat_q;
        tmoLat_d  = tmoLat_q;
        done_d    = 1'b0;
        fail_d    = fail_q;
        tmo_d     = tmo_q;
        unique case (state_q)
            ST_ESC: begin
                if (RX_VALID && (RX_DATA == OP_EN))  enable_d = 1'b1;
                if (RX_VALID && (RX_DATA == OP_DIS)) enable_d = 1'b0;
            end
            ST_ARG: begin
                if (RX_VALID) begin
                    if (runRejected) begin
                        failLat_d = 1'b1;
                        tmoLat_d  = 1'b0;
                    end else begin
                        arg_d = RX_DATA[5:0];
                    end
                end
            end
            ST_ISSUE: begin
                cmd_d = arg_q;
            end
            ST_WAIT_START: begin
                if (DEBUG_RUNNING) begin
                    cmd_d = CMD_NONE;
                end else if (timerExpire) begin
                    cmd_d     = CMD_NONE;
                    failLat_d = 1'b1;
                    tmoLat_d  = 1'b1;
                end
            end
            ST_WAIT_END: begin
                if (!DEBUG_RUNNING) begin
                    failLat_d = DEBUG_ERR;
                    tmoLat_d  = 1'b0;
                end else if (timerExpire) begin
                    cmd_d     = CMD_NONE;
                    failLat_d = 1'b1;
                    tmoLat_d  = 1'b1;
                end
            end
            ST_REPORT: begin
                done_d = 1'b1;
                fail_d = failLat_q;
                tmo_d  = tmoLat_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            enable_q  <= 1'b0;
            cmd_q     <= CMD_NONE;
            arg_q     <= CMD_NONE;
            failLat_q <= 1'b0;
            tmoLat_q  <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            enable_q  <= enable_d;
            cmd_q     <= cmd_d;
            arg_q     <= arg_d;
            failLat_q <= failLat_d;
            tmoLat_q  <= tmoLat_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
            tmo_q     <= tmo_d;
        end
    end

    assign DEBUG_TESTER_ENABLE = enable_q;
    assign DEBUG_COMMAND       = cmd_q;
    assign CMD_DONE            = done_q;
    assign CMD_FAIL            = fail_q;
    assign CMD_TIMEOUT         = tmo_q;
    assign BUSY                = isBusy(state_q);

endmodule

// File: tb/tb_cmsdk_debug_tester_ctrl.sv
// Directed bench for cmsdk_debug_tester_ctrl: byte protocol, run handshake, rejects, reset.
// The timeout scenario is exercised only when CMSDK_DBGCTRL_TIMEOUT_EN is defined.
module tb_cmsdk_debug_tester_ctrl;

    logic       CLK = 1'b0;
    logic       RESETn;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       testerRunning;
    logic       debugRunning;
    logic       DEBUG_ERR;
    logic       DEBUG_TESTER_ENABLE;
    logic [5:0] DEBUG_COMMAND;
    logic       CMD_DONE;
    logic       CMD_FAIL;
    logic       CMD_TIMEOUT;
    logic       BUSY;

    int checkCount = 0;
    int errorCount = 0;

    always #5 CLK = ~CLK;

    // The running line is pulled up whenever the tester is not connected to P0.
    assign debugRunning = DEBUG_TESTER_ENABLE ? testerRunning : 1'b1;

    cmsdk_debug_tester_ctrl #(
        .TIMEOUT_CYC (16),
        .CNT_W       (5)
    ) dut (
        .CLK                 (CLK),
        .RESETn              (RESETn),
        .RX_DATA             (RX_DATA),
        .RX_VALID            (RX_VALID),
        .DEBUG_RUNNING       (debugRunning),
        .DEBUG_ERR           (DEBUG_ERR),
        .DEBUG_TESTER_ENABLE (DEBUG_TESTER_ENABLE),
        .DEBUG_COMMAND       (DEBUG_COMMAND),
        .CMD_DONE            (CMD_DONE),
        .CMD_FAIL            (CMD_FAIL),
        .CMD_TIMEOUT         (CMD_TIMEOUT),
        .BUSY                (BUSY)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Each byte is a one-cycle strobe driven on a falling edge; returns on the
    // falling edge right after the rising edge that captured it.
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge CLK);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        @(negedge CLK);
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".en"},   32'(DEBUG_TESTER_ENABLE), 32'd0);
        checkOutput({tag, ".cmd"},  32'(DEBUG_COMMAND),       32'd0);
        checkOutput({tag, ".done"}, 32'(CMD_DONE),            32'd0);
        checkOutput({tag, ".fail"}, 32'(CMD_FAIL),            32'd0);
        checkOutput({tag, ".tmo"},  32'(CMD_TIMEOUT),         32'd0);
        checkOutput({tag, ".busy"}, 32'(BUSY),                32'd0);
    endtask

    task automatic startRun(input logic [7:0] arg);
        applyStimulus(8'h1B);
        applyStimulus(8'h13);
        applyStimulus(arg);
    endtask

    // Full handshake with command 5: running rises a few cycles after the command
    // shows, falls ten cycles later with the given error flag. Two stray bytes are
    // sent mid-run and must be dropped.
    task automatic runWithTester(input logic err, input string tag);
        startRun(8'h05);
        checkOutput({tag, ".issueCmd"}, 32'(DEBUG_COMMAND), 32'd0);
        checkOutput({tag, ".issueBusy"}, 32'(BUSY), 32'd1);
        @(negedge CLK);
        checkOutput({tag, ".cmdUp"}, 32'(DEBUG_COMMAND), 32'd5);
        @(negedge CLK);
        @(negedge CLK);
        checkOutput({tag, ".cmdHeld"}, 32'(DEBUG_COMMAND), 32'd5);
        testerRunning = 1'b1;
        @(negedge CLK);
        checkOutput({tag, ".cmdCleared"}, 32'(DEBUG_COMMAND), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            RX_VALID = (i == 2) || (i == 4);
            RX_DATA  = (i == 2) ? 8'h1B : 8'h12;
        end
        RX_VALID      = 1'b0;
        DEBUG_ERR     = err;
        testerRunning = 1'b0;
        @(negedge CLK);
        checkOutput({tag, ".doneEarly"}, 32'(CMD_DONE), 32'd0);
        checkOutput({tag, ".reportBusy"}, 32'(BUSY), 32'd1);
        @(negedge CLK);
        checkOutput({tag, ".done"}, 32'(CMD_DONE), 32'd1);
        checkOutput({tag, ".fail"}, 32'(CMD_FAIL), 32'(err));
        checkOutput({tag, ".tmo"}, 32'(CMD_TIMEOUT), 32'd0);
        checkOutput({tag, ".idleBusy"}, 32'(BUSY), 32'd0);
        DEBUG_ERR = 1'b0;
        @(negedge CLK);
        checkOutput({tag, ".donePulse"}, 32'(CMD_DONE), 32'd0);
        checkOutput({tag, ".failHold"}, 32'(CMD_FAIL), 32'(err));
        checkOutput({tag, ".enKept"}, 32'(DEBUG_TESTER_ENABLE), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RESETn        = 1'b0;
        RX_DATA       = 8'h00;
        RX_VALID      = 1'b0;
        testerRunning = 1'b0;
        DEBUG_ERR     = 1'b0;
        #12;
        checkResetValues("reset");
        @(negedge CLK);
        RESETn = 1'b1;

        $display("[TB] enable via ESC 0x11");
        applyStimulus(8'h11);
        checkOutput("bareOpIgnored", 32'(DEBUG_TESTER_ENABLE), 32'd0);
        applyStimulus(8'h1B);
        checkOutput("escEnStill0", 32'(DEBUG_TESTER_ENABLE), 32'd0);
        checkOutput("escBusy", 32'(BUSY), 32'd0);
        applyStimulus(8'h11);
        checkOutput("enableSet", 32'(DEBUG_TESTER_ENABLE), 32'd1);
        checkOutput("enableBusy", 32'(BUSY), 32'd0);

        $display("[TB] run with tester error, then clean run");
        runWithTester(1'b1, "runErr");
        runWithTester(1'b0, "runPass");

        $display("[TB] rejected runs");
        startRun(8'h40);
        checkOutput("zeroArg.cmd", 32'(DEBUG_COMMAND), 32'd0);
        checkOutput("zeroArg.doneEarly", 32'(CMD_DONE), 32'd0);
        @(negedge CLK);
        checkOutput("zeroArg.done", 32'(CMD_DONE), 32'd1);
        checkOutput("zeroArg.fail", 32'(CMD_FAIL), 32'd1);
        checkOutput("zeroArg.tmo", 32'(CMD_TIMEOUT), 32'd0);
        applyStimulus(8'h1B);
        applyStimulus(8'h12);
        checkOutput("disable", 32'(DEBUG_TESTER_ENABLE), 32'd0);
        startRun(8'h05);
        checkOutput("disRun.cmd", 32'(DEBUG_COMMAND), 32'd0);
        @(negedge CLK);
        checkOutput("disRun.done", 32'(CMD_DONE), 32'd1);
        checkOutput("disRun.fail", 32'(CMD_FAIL), 32'd1);
        checkOutput("disRun.cmd2", 32'(DEBUG_COMMAND), 32'd0);

        applyStimulus(8'h1B);
        applyStimulus(8'h11);
        checkOutput("reEnable", 32'(DEBUG_TESTER_ENABLE), 32'd1);

`ifdef CMSDK_DBGCTRL_TIMEOUT_EN
        $display("[TB] timeout with running held low");
        startRun(8'h07);
        for (int i = 1; i <= 16; i++) begin
            @(negedge CLK);
        end
        checkOutput("tmo.cmdLast", 32'(DEBUG_COMMAND), 32'd7);
        @(negedge CLK);
        checkOutput("tmo.cmdDropped", 32'(DEBUG_COMMAND), 32'd0);
        checkOutput("tmo.doneEarly", 32'(CMD_DONE), 32'd0);
        @(negedge CLK);
        checkOutput("tmo.done", 32'(CMD_DONE), 32'd1);
        checkOutput("tmo.fail", 32'(CMD_FAIL), 32'd1);
        checkOutput("tmo.tmo", 32'(CMD_TIMEOUT), 32'd1);
        @(negedge CLK);
        checkOutput("tmo.tmoHold", 32'(CMD_TIMEOUT), 32'd1);
`endif

        $display("[TB] running already high at WAIT_START, then reset in WAIT_END");
        startRun(8'h05);
        testerRunning = 1'b1;
        @(negedge CLK);
        checkOutput("fastStart.cmd", 32'(DEBUG_COMMAND), 32'd5);
        @(negedge CLK);
        checkOutput("fastStart.cmdCleared", 32'(DEBUG_COMMAND), 32'd0);
        @(negedge CLK);
        checkOutput("waitEnd.busy", 32'(BUSY), 32'd1);
        #2;
        RESETn = 1'b0;
        #1;
        checkResetValues("midReset");
        @(negedge CLK);
        RESETn        = 1'b1;
        testerRunning = 1'b0;
        @(negedge CLK);
        checkResetValues("postReset");

        applyStimulus(8'h1B);
        applyStimulus(8'h11);
        checkOutput("recover.en", 32'(DEBUG_TESTER_ENABLE), 32'd1);
        applyStimulus(8'h1B);
        applyStimulus(8'h41);
        checkOutput("badOp.busy", 32'(BUSY), 32'd0);
        checkOutput("badOp.en", 32'(DEBUG_TESTER_ENABLE), 32'd1);
        applyStimulus(8'h41);
        applyStimulus(8'h12);
        checkOutput("stray.en", 32'(DEBUG_TESTER_ENABLE), 32'd1);
        checkOutput("stray.done", 32'(CMD_DONE), 32'd0);
        applyStimulus(8'h1B);
        applyStimulus(8'h12);
        checkOutput("finalDisable", 32'(DEBUG_TESTER_ENABLE), 32'd0);
        checkOutput("finalBusy", 32'(BUSY), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
